io_sequence_monitor: RTL and testbench

- Synthesizable, parametrised IO sequence checker for rapcore self-test and harness use.
- Watches a WIDTH-bit IO bus for an ordered list of up to DEPTH masked patterns, with a per-step timeout.
- Optional strict mode fails on unexpected stable values.
- Reports pass/fail with the failing step index and the observed value. Sits between the mprj_io pins (or loop-back) and the housekeeping/SPI register file.

---
 rtl/io_sequence_monitor_pkg.sv | 17 +
 rtl/io_sync_bus.sv | 28 ++
 rtl/io_sequence_monitor.sv | 173 +++++++++++++++++
 tb/tb_io_sequence_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_sequence_monitor_pkg.sv
// io_sequence_monitor_pkg: shared state and fail-reason encodings for the IO sequence monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_sequence_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_t;

  localparam logic [1:0] FR_NONE       = 2'd0;
  localparam logic [1:0] FR_TIMEOUT    = 2'd1;
  localparam logic [1:0] FR_UNEXPECTED = 2'd2;

endpackage

// File: rtl/io_sync_bus.sv
// io_sync_bus: multi-flop synchroniser for an asynchronous bus.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clock, reset (sync, active-high), d (async bus in), q (synchronised bus out).
module io_sync_bus #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/io_sequence_monitor.sv
// io_sequence_monitor: checks a synchronised IO bus against an ordered table of masked patterns.
// Latency: a step is accepted SYNC_STAGES+STABLE_CYCLES cycles after mon_in settles; status is registered.
// Backpressure: none; start is ignored while busy and table writes are ignored while busy.
// Ports: CLK/reset (sync, active-high); pat_we/pat_addr/pat_data/pat_mask load the pattern table;
//   seq_len/timeout_cycles configure a run and are latched at start; start/abort control the run;
//   mon_in is the async bus; busy/pass/fail/fail_reason/step_idx/observed report status.
module io_sequence_monitor
  import io_sequence_monitor_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_W     = 20,
  parameter int STABLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STRICT        = 0
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     pat_we,
  input  logic [$clog2(DEPTH)-1:0] pat_addr,
  input  logic [WIDTH-1:0]         pat_data,
  input  logic [WIDTH-1:0]         pat_mask,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic [TIMEOUT_W-1:0]     timeout_cycles,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         mon_in,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_reason,
  output logic [$clog2(DEPTH):0]   step_idx,
  output logic [WIDTH-1:0]         observed
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STABLE_CYCLES);

  logic [WIDTH-1:0]     tbl_data [DEPTH];
  logic [WIDTH-1:0]     tbl_mask [DEPTH];
  logic [WIDTH-1:0]     s_in;
  mon_state_t           state;
  logic [LW-1:0]        len_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [SW-1:0]        stable_cnt;
  logic [SW-1:0]        bad_cnt;

  logic [AW-1:0] cur_i, prv_i;
  logic          cur_match, prv_match, bad;
  logic          accept, timed_out, unexpected;
  logic [SW-1:0] stable_nxt, bad_nxt;
  logic [LW-1:0] len_clamped, step_nxt;

  io_sync_bus #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (CLK),
    .reset (reset),
    .d     (mon_in),
    .q     (s_in)
  );

  // Table is deliberately not reset; it is only writable between runs.
  always_ff @(posedge CLK) begin
    if (pat_we && !busy) begin
      tbl_data[pat_addr] <= pat_data;
      tbl_mask[pat_addr] <= pat_mask;
    end
  end

  assign cur_i = step_idx[AW-1:0];
  assign prv_i = cur_i - 1'b1;

  always_comb begin
    cur_match   = ((s_in ^ tbl_data[cur_i]) & tbl_mask[cur_i]) == '0;
    // Step 0 has no previous step to tolerate.
    prv_match   = (step_idx != '0) && (((s_in ^ tbl_data[prv_i]) & tbl_mask[prv_i]) == '0);
    bad         = (STRICT != 0) && !cur_match && !prv_match;

    stable_nxt  = '0;
    if (cur_match) stable_nxt = (stable_cnt == SC_MAX) ? stable_cnt : stable_cnt + 1'b1;

    // An unexpected value must hold the same raw value to count as stable;
    // observed carries last cycle's s_in while running.
    bad_nxt     = '0;
    if (bad) begin
      if (bad_cnt != '0 && s_in == observed)
        bad_nxt = (bad_cnt == SC_MAX) ? bad_cnt : bad_cnt + 1'b1;
      else
        bad_nxt = SW'(1);
    end

    accept      = (state == RUN) && (stable_nxt == SC_MAX);
    timed_out   = (state == RUN) && (tmo_q != '0) && (tmo_cnt == tmo_q - 1'b1);
    unexpected  = (state == RUN) && bad && (bad_nxt == SC_MAX);
    step_nxt    = step_idx + 1'b1;
    len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= FR_NONE;
      step_idx    <= '0;
      observed    <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      tmo_cnt     <= '0;
      stable_cnt  <= '0;
      bad_cnt     <= '0;
    end else begin
      if (state == RUN) observed <= s_in;

      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
        fail_reason <= FR_NONE;
      end else if (start && state != RUN) begin
        pass        <= 1'b0;
        fail        <= 1'b0;
        fail_reason <= FR_NONE;
        step_idx    <= '0;
        tmo_cnt     <= '0;
        stable_cnt  <= '0;
        bad_cnt     <= '0;
        len_q       <= len_clamped;
        tmo_q       <= timeout_cycles;
        if (len_clamped == '0) begin
          state <= PASS;
          pass  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else if (state == RUN) begin
        // Accept outranks timeout, which outranks the unexpected-value check.
        if (accept) begin
          step_idx   <= step_nxt;
          stable_cnt <= '0;
          tmo_cnt    <= '0;
          bad_cnt    <= '0;
          if (step_nxt == len_q) begin
            state <= PASS;
            pass  <= 1'b1;
            busy  <= 1'b0;
          end
        end else if (timed_out) begin
          state       <= FAIL;
          fail        <= 1'b1;
          fail_reason <= FR_TIMEOUT;
          busy        <= 1'b0;
        end else if (unexpected) begin
          state       <= FAIL;
          fail        <= 1'b1;
          fail_reason <= FR_UNEXPECTED;
          busy        <= 1'b0;
        end else begin
          stable_cnt <= stable_nxt;
          bad_cnt    <= bad_nxt;
          tmo_cnt    <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_sequence_monitor.sv
// tb_io_sequence_monitor: scoreboard bench for io_sequence_monitor with a window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_sequence_monitor;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int TMO_W  = 20;
  localparam int SC     = 2;
  localparam int SYNC   = 2;
  localparam int STRICT = 1;

  logic        clk = 1'b0;
  logic        reset, pat_we, start, abort;
  logic [3:0]  pat_addr;
  logic [7:0]  pat_data, pat_mask, mon_in;
  logic [4:0]  seq_len;
  logic [19:0] timeout_cycles;
  logic        busy, pass, fail;
  logic [1:0]  fail_reason;
  logic [4:0]  step_idx;
  logic [7:0]  observed;

  always #5 clk = ~clk;

  io_sequence_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_W(TMO_W),
    .STABLE_CYCLES(SC), .SYNC_STAGES(SYNC), .STRICT(STRICT)
  ) dut (
    .CLK(clk), .reset(reset), .pat_we(pat_we), .pat_addr(pat_addr),
    .pat_data(pat_data), .pat_mask(pat_mask), .seq_len(seq_len),
    .timeout_cycles(timeout_cycles), .start(start), .abort(abort),
    .mon_in(mon_in), .busy(busy), .pass(pass), .fail(fail),
    .fail_reason(fail_reason), .step_idx(step_idx), .observed(observed)
  );

  typedef struct {
    logic       p;
    logic       f;
    logic [1:0] r;
    logic [4:0] step;
    logic [7:0] obs;
    bit         chk_obs;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] wave[$];
  logic [7:0] m_data [DEPTH];
  logic [7:0] m_mask [DEPTH];
  logic [7:0] walk [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                            8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int last_lat  = -1;
  int busy_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Synced sample seen by the checker k cycles after the start edge.
  function automatic logic [7:0] samp(input int k);
    int i;
    i = k - SYNC;
    if (i < 0) i = 0;
    if (i > wave.size() - 1) i = wave.size() - 1;
    return wave[i];
  endfunction

  function automatic bit hit(input int step, input logic [7:0] v);
    return ((v ^ m_data[step]) & m_mask[step]) == 8'h00;
  endfunction

  function automatic bit is_bad(input int step, input logic [7:0] v);
    return !hit(step, v) && !(step > 0 && hit(step - 1, v));
  endfunction

  // Outcome of a run from the rules: a step is taken at the first cycle whose
  // last SC samples (all inside the step) match; a step fails when it has lasted
  // tmo cycles, or when SC identical samples match neither this nor the previous step.
  function automatic exp_t model(input int len_in, input int tmo);
    exp_t e;
    int len, step, st;
    bit acc, bad;
    logic [7:0] s;
    len = (len_in > DEPTH) ? DEPTH : len_in;
    e.p = 0; e.f = 0; e.r = 0; e.step = 0; e.obs = 0; e.chk_obs = 1; e.lat = -1;
    if (len == 0) begin
      e.p = 1; e.chk_obs = 0; e.lat = 0;
      return e;
    end
    step = 0;
    st   = 1;
    for (int k = 1; k < 20000; k++) begin
      s   = samp(k);
      acc = 1;
      bad = (STRICT != 0);
      for (int j = 0; j < SC; j++) begin
        if (k - j < st || !hit(step, samp(k - j))) acc = 0;
        if (k - j < st || !is_bad(step, samp(k - j)) || samp(k - j) != s) bad = 0;
      end
      if (acc) begin
        step++;
        st = k + 1;
        if (step == len) begin
          e.p = 1; e.step = 5'(step); e.obs = s; e.lat = k;
          return e;
        end
      end else if (tmo != 0 && k - st == tmo - 1) begin
        e.f = 1; e.r = 2'd1; e.step = 5'(step); e.obs = s; e.lat = k;
        return e;
      end else if (bad) begin
        e.f = 1; e.r = 2'd2; e.step = 5'(step); e.obs = s; e.lat = k;
        return e;
      end
    end
    return e;
  endfunction

  task automatic write_tbl(input int addr, input logic [7:0] d, input logic [7:0] m, input bit upd);
    @(negedge clk);
    pat_we = 1; pat_addr = 4'(addr); pat_data = d; pat_mask = m;
    if (upd) begin m_data[addr] = d; m_mask[addr] = m; end
    @(negedge clk);
    pat_we = 0;
  endtask

  task automatic do_run(input int len, input int tmo);
    int guard;
    @(negedge clk);
    abort = 1; mon_in = wave[0];
    @(negedge clk);
    abort = 0;
    repeat (SYNC + 1) @(negedge clk);
    sb.push_back(model(len, tmo));
    seq_len = 5'(len); timeout_cycles = 20'(tmo);
    start = 1; start_cyc = cyc + 1;
    for (int i = 1; i < wave.size(); i++) begin
      @(negedge clk);
      start = 0; mon_in = wave[i];
    end
    @(negedge clk);
    start = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL run_completion: no result after %0d cycles, %0d pending", guard, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: a rising pass/fail is a completed run; compare with the scoreboard head.
  initial begin : monitor
    logic done_prev, done_now;
    exp_t e;
    done_prev = 0;
    forever begin
      @(negedge clk);
      done_now = pass | fail;
      if (done_now && !done_prev && !reset) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_completion: pass=%0b fail=%0b with no run expected", pass, fail);
        end else begin
          e = sb.pop_front();
          last_lat = cyc - start_cyc;
          check("pass", 32'(pass), 32'(e.p));
          check("fail", 32'(fail), 32'(e.f));
          check("fail_reason", 32'(fail_reason), 32'(e.r));
          check("step_idx", 32'(step_idx), 32'(e.step));
          if (e.chk_obs) check("observed", 32'(observed), 32'(e.obs));
          check("latency", 32'(last_lat), 32'(e.lat));
        end
      end
      done_prev = done_now;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    int guard, vi, len, len_eff, b0;
    logic [7:0] v;
    reset = 1; pat_we = 0; pat_addr = 0; pat_data = 0; pat_mask = 0;
    seq_len = 0; timeout_cycles = 0; start = 0; abort = 0; mon_in = 0;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_reason", 32'(fail_reason), 0);
    check("rst_step", 32'(step_idx), 0);
    check("rst_observed", 32'(observed), 0);
    reset = 0;

    // Walking sequence, values 50 cycles apart.
    for (int i = 0; i < 12; i++) write_tbl(i, walk[i], 8'hFF, 1);
    wave.delete();
    for (int i = 0; i < 12; i++) repeat (50) wave.push_back(walk[i]);
    do_run(12, 1000);
    check("walk_pass", 32'(pass), 1);
    check("walk_step", 32'(step_idx), 12);
    check("walk_fail", 32'(fail), 0);
    check("walk_latency", 32'(last_lat), 553);

    // Timeout: only the first two values ever appear.
    write_tbl(0, 8'h11, 8'hFF, 1);
    write_tbl(1, 8'h22, 8'hFF, 1);
    write_tbl(2, 8'h33, 8'hFF, 1);
    wave.delete();
    repeat (10) wave.push_back(8'h11);
    wave.push_back(8'h22);
    do_run(3, 100);
    check("tmo_fail", 32'(fail), 1);
    check("tmo_reason", 32'(fail_reason), 1);
    check("tmo_step", 32'(step_idx), 2);
    check("tmo_latency", 32'(last_lat), 113);

    // Mask and glitch: one-cycle 0x80 ignored, 0x8F held three cycles accepted.
    write_tbl(0, 8'h00, 8'hFF, 1);
    write_tbl(1, 8'h80, 8'h80, 1);
    wave.delete();
    repeat (10) wave.push_back(8'h00);
    wave.push_back(8'h80);
    repeat (5) wave.push_back(8'h00);
    repeat (3) wave.push_back(8'h8F);
    repeat (5) wave.push_back(8'h00);
    do_run(2, 500);
    check("glitch_pass", 32'(pass), 1);
    check("glitch_latency", 32'(last_lat), 19);
    check("glitch_observed", 32'(observed), 32'h8F);

    // Strict: a held 0x55 matches neither step.
    write_tbl(0, 8'h01, 8'hFF, 1);
    write_tbl(1, 8'h02, 8'hFF, 1);
    wave.delete();
    repeat (10) wave.push_back(8'h01);
    wave.push_back(8'h55);
    do_run(2, 1000);
    check("strict_fail", 32'(fail), 1);
    check("strict_reason", 32'(fail_reason), 2);
    check("strict_observed", 32'(observed), 32'h55);
    check("strict_step", 32'(step_idx), 1);

    // Abort mid-run, with a table write attempted while busy.
    for (int i = 0; i < 12; i++) write_tbl(i, walk[i], 8'hFF, 1);
    @(negedge clk);
    mon_in = 8'h01;
    repeat (3) @(negedge clk);
    seq_len = 5'd12; timeout_cycles = 20'd1000; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 32'(busy), 1);
    check("abort_step_before", 32'(step_idx), 1);
    write_tbl(0, 8'hEE, 8'hFF, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_busy", 32'(busy), 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_fail", 32'(fail), 0);
    check("abort_step_held", 32'(step_idx), 1);
    wave.delete();
    for (int i = 0; i < 12; i++) repeat (20) wave.push_back(walk[i]);
    do_run(12, 1000);
    check("we_ignored_pass", 32'(pass), 1);

    // Zero-length run.
    b0 = busy_cnt;
    wave.delete();
    wave.push_back(8'h00);
    do_run(0, 100);
    check("len0_pass", 32'(pass), 1);
    check("len0_latency", 32'(last_lat), 0);
    check("len0_busy_cycles", 32'(busy_cnt - b0), 0);

    // Reset mid-run at step 5, then a fresh run from step 0.
    @(negedge clk);
    mon_in = walk[0];
    repeat (3) @(negedge clk);
    seq_len = 5'd12; timeout_cycles = 20'd1000; start = 1;
    @(negedge clk);
    start = 0;
    guard = 0; vi = 0;
    while (step_idx != 5'd5 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (guard % 6 == 0 && vi < 11) begin vi++; mon_in = walk[vi]; end
    end
    check("rstmid_step5", 32'(step_idx), 5);
    reset = 1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_pass", 32'(pass), 0);
    check("rstmid_fail", 32'(fail), 0);
    check("rstmid_reason", 32'(fail_reason), 0);
    check("rstmid_step", 32'(step_idx), 0);
    check("rstmid_observed", 32'(observed), 0);
    reset = 0;
    wave.delete();
    for (int i = 0; i < 12; i++) repeat (10) wave.push_back(walk[i]);
    do_run(12, 1000);
    check("rstmid_rerun_step", 32'(step_idx), 12);

    // Randomised runs; the first uses an oversize seq_len.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 7))
          0:       write_tbl(i, 8'($urandom), 8'h00, 1);
          1, 2:    write_tbl(i, 8'($urandom), 8'hFF, 1);
          default: write_tbl(i, 8'($urandom), 8'($urandom), 1);
        endcase
      end
      len     = (r == 0) ? 20 : int'($urandom_range(1, 16));
      len_eff = (len > DEPTH) ? DEPTH : len;
      wave.delete();
      for (int i = 0; i < len_eff; i++) begin
        if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 2)) wave.push_back(8'($urandom));
        v = (m_data[i] & m_mask[i]) | (8'($urandom) & ~m_mask[i]);
        repeat ($urandom_range(1, 6)) wave.push_back(v);
      end
      do_run(len, int'($urandom_range(20, 150)));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
